// File: rtl/bsg_front_side_bus_hop_in_fc.sv
// Flow-controlled front-side-bus hop input: els_p-deep FIFO whose head is forked to fanout_p destinations.
// Optional statistics counters are enabled by defining BSG_FSB_HOP_IN_STATS_EN.
module bsg_front_side_bus_hop_in_fc #(
  parameter int width_p      = 16,
  parameter int fanout_p     = 2,
  parameter int els_p        = 4,
  parameter int stat_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [width_p-1:0]            data_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic [fanout_p-1:0]           accept_mask_i,
  output logic [fanout_p*width_p-1:0]   data_o,
  output logic [fanout_p-1:0]           v_o,
  input  logic [fanout_p-1:0]           ready_i
`ifdef BSG_FSB_HOP_IN_STATS_EN
  ,
  output logic [stat_width_p-1:0]       fwd_count_o,
  output logic [stat_width_p-1:0]       stall_count_o
`endif
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0] full_cnt_lp = (ptr_w_lp + 1)'(els_p);

  // Storage is deliberately not reset; only pointers and bookkeeping are.
  logic [width_p-1:0]  data_mem [els_p];
  logic [fanout_p-1:0] mask_mem [els_p];

  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [ptr_w_lp:0]   count_r, count_n;
  logic [fanout_p-1:0] sent_r;
  logic                ready_r;

  logic                empty;
  logic                enq, deq;
  logic [width_p-1:0]  head_data;
  logic [fanout_p-1:0] head_mask;
  logic [fanout_p-1:0] fire, done;

  assign empty     = (count_r == '0);
  assign head_data = data_mem[rd_ptr_r];
  assign head_mask = mask_mem[rd_ptr_r];

  // Handshake: a beat moves on a port only when its valid and ready are both
  // high at a rising clk_i edge; valids never depend on the matching ready.
  assign v_o    = {fanout_p{~empty}} & head_mask & ~sent_r;
  assign fire   = v_o & ready_i;
  assign done   = sent_r | fire | ~head_mask;
  assign deq    = ~empty & (&done);
  assign enq    = v_i & ready_r;

  assign ready_o = ready_r;
  assign data_o  = {fanout_p{head_data}};

  always_comb begin
    count_n = count_r;
    case ({enq, deq})
      2'b10:   count_n = count_r + 1'b1;
      2'b01:   count_n = count_r - 1'b1;
      default: count_n = count_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem[wr_ptr_r] <= data_i;
      mask_mem[wr_ptr_r] <= accept_mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      sent_r   <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_n;
      // A dequeue retires the whole entry, so the per-destination flags restart.
      sent_r  <= deq ? '0 : (sent_r | fire);
      ready_r <= (count_n != full_cnt_lp);
    end
  end

`ifdef BSG_FSB_HOP_IN_STATS_EN
  logic [stat_width_p-1:0] fwd_cnt_r, stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fwd_cnt_r   <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (deq && (|head_mask)) fwd_cnt_r <= fwd_cnt_r + 1'b1;
      if (|(v_o & ~ready_i))   stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign fwd_count_o   = fwd_cnt_r;
  assign stall_count_o = stall_cnt_r;
`endif

  always_ff @(posedge clk_i) begin
    assert (fanout_p >= 1);
    assert (els_p >= 2 && ((els_p & (els_p - 1)) == 0));
    assert (stat_width_p >= 1);
    if (reset_n_i) assert (count_r <= full_cnt_lp);
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in_fc.sv
// Directed bench for the flow-controlled FSB hop input (width 16, fanout 2, depth 4).
module tb_bsg_front_side_bus_hop_in_fc;
  localparam int W = 16;
  localparam int F = 2;
  localparam int E = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [W-1:0]   data_i = '0;
  logic           v_i = 1'b0;
  logic           ready_o;
  logic [F-1:0]   mask_i = '0;
  logic [F*W-1:0] data_o;
  logic [F-1:0]   v_o;
  logic [F-1:0]   ready_i = '0;
`ifdef BSG_FSB_HOP_IN_STATS_EN
  logic [15:0]    fwd_count;
  logic [15:0]    stall_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_in_fc #(
    .width_p(W), .fanout_p(F), .els_p(E), .stat_width_p(16)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .data_i        (data_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .accept_mask_i (mask_i),
    .data_o        (data_o),
    .v_o           (v_o),
    .ready_i       (ready_i)
`ifdef BSG_FSB_HOP_IN_STATS_EN
    ,
    .fwd_count_o   (fwd_count),
    .stall_count_o (stall_count)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    @(posedge clk); #2;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL reset_v: got %b want 00", v_o); end
    @(posedge clk); #3 reset_n = 1'b1;
    tick;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", ready_o); end
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL release_v: got %b want 00", v_o); end
  endtask

  task automatic test_mid_reset;
    ready_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = 16'h0100 + 16'(i); mask_i = 2'b11;
      tick;
    end
    v_i = 1'b0;
    checks++; if (v_o !== 2'b11) begin errors++; $display("FAIL midrst_pre_v: got %b want 11", v_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL midrst_v: got %b want 00", v_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", ready_o); end
    @(posedge clk); #3 reset_n = 1'b1;
    tick;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_rel_ready: got %b want 1", ready_o); end
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL midrst_rel_v: got %b want 00", v_o); end
    ready_i = 2'b11; v_i = 1'b1; data_i = 16'h0777; mask_i = 2'b11;
    tick;
    v_i = 1'b0;
    checks++; if (v_o !== 2'b11) begin errors++; $display("FAIL midrst_new_v: got %b want 11", v_o); end
    checks++; if (data_o !== 32'h07770777) begin errors++; $display("FAIL midrst_new_data: got %h want 07770777", data_o); end
    tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL midrst_after_v: got %b want 00", v_o); end
  endtask

  task automatic test_single;
    ready_i = 2'b11; v_i = 1'b1; data_i = 16'hA5A5; mask_i = 2'b11;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL single_nobypass: got %b want 00", v_o); end
    tick;
    v_i = 1'b0;
    checks++; if (v_o !== 2'b11) begin errors++; $display("FAIL single_v: got %b want 11", v_o); end
    checks++; if (data_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_data: got %h want a5a5a5a5", data_o); end
    tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL single_after: got %b want 00", v_o); end
  endtask

  task automatic test_skew;
    ready_i = 2'b00; v_i = 1'b1; data_i = 16'h1234; mask_i = 2'b11;
    tick;
    v_i = 1'b0;
    tick;
    checks++; if (v_o !== 2'b11) begin errors++; $display("FAIL skew_hold_v: got %b want 11", v_o); end
    ready_i = 2'b01;
    tick;
    checks++; if (v_o !== 2'b10) begin errors++; $display("FAIL skew_ch0_done: got %b want 10", v_o); end
    checks++; if (data_o !== 32'h12341234) begin errors++; $display("FAIL skew_data_stable: got %h want 12341234", data_o); end
    ready_i = 2'b10;
    tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL skew_dequeued: got %b want 00", v_o); end
    ready_i = 2'b11;
    tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL skew_no_dup: got %b want 00", v_o); end
  endtask

  task automatic test_full;
    ready_i = 2'b00; mask_i = 2'b11;
    for (int i = 1; i <= 5; i++) exp_q.push_back(16'(i));
    for (int i = 1; i <= 4; i++) begin
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_%0d: got %b want 1", i, ready_o); end
      v_i = 1'b1; data_i = 16'(i);
      tick;
    end
    data_i = 16'd5;
    for (int c = 0; c < 2; c++) begin
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_blocked_%0d: got %b want 0", c, ready_o); end
      checks++; if (data_o !== 32'h00010001) begin errors++; $display("FAIL full_head_%0d: got %h want 00010001", c, data_o); end
      tick;
    end
    ready_i = 2'b11;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (c == 0) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_deq_blocked: got %b want 0", ready_o); end
      end
      if (c == 1) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_space_back: got %b want 1", ready_o); end
      end
      checks++;
      if (v_o !== 2'b11 || data_o !== {exp_q[0], exp_q[0]}) begin
        errors++; $display("FAIL full_order_%0d: got v=%b d=%h want v=11 d=%h", c, v_o, data_o, {exp_q[0], exp_q[0]});
      end
      void'(exp_q.pop_front());
      tick;
      if (c == 1) v_i = 1'b0;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d left want 0", exp_q.size()); end
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL full_empty_v: got %b want 00", v_o); end
    v_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_masks;
    ready_i = 2'b11;
    v_i = 1'b1; data_i = 16'h00AA; mask_i = 2'b00;
    tick;
    data_i = 16'h0101; mask_i = 2'b01;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL mask00_hidden: got %b want 00", v_o); end
    tick;
    data_i = 16'h0202; mask_i = 2'b10;
    checks++; if (v_o !== 2'b01 || data_o[15:0] !== 16'h0101) begin errors++; $display("FAIL mask01: got v=%b d=%h want v=01 d=0101", v_o, data_o[15:0]); end
    tick;
    v_i = 1'b0;
    checks++; if (v_o !== 2'b10 || data_o[31:16] !== 16'h0202) begin errors++; $display("FAIL mask10: got v=%b d=%h want v=10 d=0202", v_o, data_o[31:16]); end
    tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL mask_empty: got %b want 00", v_o); end
    // All four slots must still be usable.
    ready_i = 2'b00; mask_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mask_leak_%0d: got %b want 1", i, ready_o); end
      v_i = 1'b1; data_i = 16'h0300 + 16'(i);
      tick;
    end
    v_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL mask_refull: got %b want 0", ready_o); end
    ready_i = 2'b11;
    repeat (4) tick;
    checks++; if (v_o !== 2'b00) begin errors++; $display("FAIL mask_redrain: got %b want 00", v_o); end
  endtask

`ifdef BSG_FSB_HOP_IN_STATS_EN
  task automatic test_stats;
    #2 reset_n = 1'b0;
    #2;
    checks++; if (fwd_count !== 16'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", fwd_count, stall_count); end
    @(posedge clk); #3 reset_n = 1'b1;
    tick;
    ready_i = 2'b00; mask_i = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      v_i = 1'b1; data_i = 16'(i);
      tick;
    end
    data_i = 16'd5;
    repeat (3) tick;
    ready_i = 2'b11;
    tick;
    tick;
    v_i = 1'b0;
    repeat (4) tick;
    checks++; if (fwd_count !== 16'd5) begin errors++; $display("FAIL stats_fwd: got %0d want 5", fwd_count); end
    checks++; if (stall_count !== 16'd6) begin errors++; $display("FAIL stats_stall: got %0d want 6", stall_count); end
  endtask
`endif

  initial begin
    test_reset;
    test_mid_reset;
    test_single;
    test_skew;
    test_full;
    test_masks;
`ifdef BSG_FSB_HOP_IN_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
